// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: op codes, memory-controller width codes and
// small decode helpers used by the LSU and its store buffer.
package lsu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LH  = 3'd1,
      OP_LW  = 3'd2,
      OP_LBU = 3'd3,
      OP_LHU = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } lsu_op_e;

   localparam logic [2:0] MC_W_BYTE = 3'b001;
   localparam logic [2:0] MC_W_HALF = 3'b010;
   localparam logic [2:0] MC_W_WORD = 3'b100;

   function automatic logic op_is_store(logic [2:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [2:0] op_width(logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return MC_W_BYTE;
         OP_LH, OP_LHU, OP_SH: return MC_W_HALF;
         default:              return MC_W_WORD;
      endcase
   endfunction

   function automatic logic width_misaligned(logic [2:0] width, logic [1:0] lo);
      return ((width == MC_W_HALF) && lo[0]) ||
             ((width == MC_W_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_store_fifo.sv
// Store buffer: circular FIFO of {addr, data, width} entries with a
// word-address compare port that searches every occupied slot.
module lsu_store_fifo
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [AW-1:0] push_addr_i,
   input  logic [DW-1:0] push_data_i,
   input  logic [2:0]    push_width_i,
   input  logic          pop_i,
   output logic [AW-1:0] head_addr_o,
   output logic [DW-1:0] head_data_o,
   output logic [2:0]    head_width_o,
   output logic          full_o,
   output logic          empty_o,
   input  logic [AW-3:0] cmp_waddr_i,
   output logic          cmp_hit_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AW-1:0]    addr_q  [DEPTH];
   logic [DW-1:0]    data_q  [DEPTH];
   logic [2:0]       width_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   assign head_addr_o  = addr_q[rd_ptr_q];
   assign head_data_o  = data_q[rd_ptr_q];
   assign head_width_o = width_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_q[wr_ptr_q]  <= push_addr_i;
         data_q[wr_ptr_q]  <= push_data_i;
         width_q[wr_ptr_q] <= push_width_i;
      end
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] off;
      off       = '0;
      cmp_hit_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) && (addr_q[i][AW-1:2] == cmp_waddr_i))
            cmp_hit_o = 1'b1;
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: buffers stores, issues loads and store drains
// to a single-outstanding memory controller and formats load writeback.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              req_ready,
   input  logic              flush,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              misalign,
   output logic              mc_req,
   output logic              mc_we,
   output logic [2:0]        mc_width,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [XLEN-1:0]   mc_wdata,
   input  logic              mc_busy,
   input  logic              mc_done,
   input  logic [XLEN-1:0]   mc_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      ST_REQ,
      ST_WAIT
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        ld_op_q;
   logic [ADDR_W-1:0] ld_addr_q;
   logic [4:0]        ld_rd_q;
   logic              ld_kill_q;
   logic              wb_valid_q, wb_we_q, misalign_q;
   logic [4:0]        wb_rd_q;
   logic [XLEN-1:0]   wb_data_q;

   logic              req_is_store, req_mis, accept, st_push, ld_accept, ld_done;
   logic [2:0]        req_width;
   logic [XLEN-1:0]   st_data;
   logic              sb_pop, sb_full, sb_empty, sb_hit;
   logic [ADDR_W-1:0] sb_head_addr;
   logic [XLEN-1:0]   sb_head_data;
   logic [2:0]        sb_head_width;

   function automatic logic [XLEN-1:0] load_extend(logic [2:0] op, logic [XLEN-1:0] d);
      case (op)
         OP_LB:   return {{(XLEN-8){d[7]}}, d[7:0]};
         OP_LBU:  return XLEN'(d[7:0]);
         OP_LH:   return {{(XLEN-16){d[15]}}, d[15:0]};
         OP_LHU:  return XLEN'(d[15:0]);
         default: return d;
      endcase
   endfunction

   assign req_is_store = op_is_store(req_op);
   assign req_width    = op_width(req_op);
   assign req_mis      = width_misaligned(req_width, req_addr[1:0]);

   assign req_ready = !rst && (req_is_store ? !sb_full : ((state_q == IDLE) && !sb_hit));
   assign accept    = req_valid && req_ready;
   assign st_push   = accept && req_is_store && !req_mis;
   assign ld_accept = accept && !req_is_store && !req_mis;

   always_comb begin
      case (req_width)
         MC_W_BYTE: st_data = XLEN'(req_wdata[7:0]);
         MC_W_HALF: st_data = XLEN'(req_wdata[15:0]);
         default:   st_data = req_wdata;
      endcase
   end

   lsu_store_fifo #(
      .AW    (ADDR_W),
      .DW    (XLEN),
      .DEPTH (SB_DEPTH)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .push_i       (st_push),
      .push_addr_i  (req_addr),
      .push_data_i  (st_data),
      .push_width_i (req_width),
      .pop_i        (sb_pop),
      .head_addr_o  (sb_head_addr),
      .head_data_o  (sb_head_data),
      .head_width_o (sb_head_width),
      .full_o       (sb_full),
      .empty_o      (sb_empty),
      .cmp_waddr_i  (req_addr[ADDR_W-1:2]),
      .cmp_hit_o    (sb_hit)
   );

   always_comb begin
      state_d  = state_q;
      mc_req   = 1'b0;
      mc_we    = 1'b0;
      mc_width = '0;
      mc_addr  = '0;
      mc_wdata = '0;
      sb_pop   = 1'b0;
      ld_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld_accept)      state_d = LD_REQ;
            else if (!sb_empty) state_d = ST_REQ;
         end
         LD_REQ: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               mc_addr  = ld_addr_q;
               mc_width = op_width(ld_op_q);
               if (!mc_busy) begin
                  mc_req  = 1'b1;
                  state_d = LD_WAIT;
               end
            end
         end
         LD_WAIT: begin
            if (mc_done) begin
               ld_done = 1'b1;
               state_d = IDLE;
            end
         end
         ST_REQ: begin
            mc_we    = 1'b1;
            mc_addr  = sb_head_addr;
            mc_width = sb_head_width;
            mc_wdata = sb_head_data;
            if (!mc_busy) begin
               mc_req  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mc_done) begin
               sb_pop  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset must silence the memory port in the very cycle it is asserted.
      if (rst) begin
         state_d  = IDLE;
         mc_req   = 1'b0;
         mc_we    = 1'b0;
         mc_width = '0;
         mc_addr  = '0;
         mc_wdata = '0;
         sb_pop   = 1'b0;
         ld_done  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ld_op_q    <= '0;
         ld_addr_q  <= '0;
         ld_rd_q    <= '0;
         ld_kill_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= accept && req_mis;
         wb_valid_q <= ld_done && !(ld_kill_q || flush);
         wb_we_q    <= ld_done && !(ld_kill_q || flush) && (ld_rd_q != '0);
         if (ld_done) begin
            wb_rd_q   <= ld_rd_q;
            wb_data_q <= load_extend(ld_op_q, mc_rdata);
         end
         if (ld_accept) begin
            ld_op_q   <= req_op;
            ld_addr_q <= req_addr;
            ld_rd_q   <= req_rd;
            ld_kill_q <= 1'b0;
         end else if ((state_q == LD_WAIT) && flush) begin
            ld_kill_q <= 1'b1;
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_we    = wb_we_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs change 1ns after the rising edge and
// outputs are sampled on the falling edge against hand-computed values.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        req_ready;
   logic        flush;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;
   logic        mc_req, mc_we;
   logic [2:0]  mc_width;
   logic [31:0] mc_addr, mc_wdata;
   logic        mc_busy, mc_done;
   logic [31:0] mc_rdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(
      .XLEN     (32),
      .ADDR_W   (32),
      .SB_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rd    (req_rd),
      .req_ready (req_ready),
      .flush     (flush),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .misalign  (misalign),
      .mc_req    (mc_req),
      .mc_we     (mc_we),
      .mc_width  (mc_width),
      .mc_addr   (mc_addr),
      .mc_wdata  (mc_wdata),
      .mc_busy   (mc_busy),
      .mc_done   (mc_done),
      .mc_rdata  (mc_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
   endtask

   // Accept cycle c0, mc_req in c1, mc_done in c2, writeback in c3.
   task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [2:0] exp_w, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_we);
      drive_req(op, addr, 32'h0, rd);
      @(negedge clk);
      check_eq("ld_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("ld_mc_req", 32'(mc_req), 32'd1);
      check_eq("ld_mc_addr", mc_addr, addr);
      check_eq("ld_mc_width", 32'(mc_width), 32'(exp_w));
      check_eq("ld_mc_we", 32'(mc_we), 32'd0);
      next_cycle();
      mc_done  = 1'b1;
      mc_rdata = rdata;
      @(negedge clk);
      check_eq("ld_mc_req_once", 32'(mc_req), 32'd0);
      check_eq("ld_wb_early", 32'(wb_valid), 32'd0);
      next_cycle();
      mc_done  = 1'b0;
      mc_rdata = 32'h0;
      @(negedge clk);
      check_eq("ld_wb_valid", 32'(wb_valid), 32'd1);
      check_eq("ld_wb_we", 32'(wb_we), 32'(exp_we));
      check_eq("ld_wb_rd", 32'(wb_rd), 32'(rd));
      check_eq("ld_wb_data", wb_data, exp_data);
      next_cycle();
      @(negedge clk);
      check_eq("ld_wb_pulse", 32'(wb_valid), 32'd0);
      next_cycle();
   endtask

   // Waits (bounded) for the next store issue, checks it and completes it.
   task automatic drain_store(input logic [31:0] exp_addr, input logic [31:0] exp_data,
                              input logic [2:0] exp_w);
      bit seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mc_req) begin
            seen = 1'b1;
            break;
         end
         next_cycle();
      end
      check_eq("st_issue_seen", 32'(seen), 32'd1);
      check_eq("st_mc_we", 32'(mc_we), 32'd1);
      check_eq("st_mc_addr", mc_addr, exp_addr);
      check_eq("st_mc_wdata", mc_wdata, exp_data);
      check_eq("st_mc_width", 32'(mc_width), 32'(exp_w));
      next_cycle();
      mc_done = 1'b1;
      next_cycle();
      mc_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_LW;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_rd    = 5'd0;
      flush     = 1'b0;
      mc_busy   = 1'b0;
      mc_done   = 1'b0;
      mc_rdata  = 32'h0;

      // Reset: every output low even with a request on the bus.
      next_cycle();
      req_valid = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
      check_eq("rst_wb_we", 32'(wb_we), 32'd0);
      check_eq("rst_misalign", 32'(misalign), 32'd0);
      check_eq("rst_mc_req", 32'(mc_req), 32'd0);
      check_eq("rst_mc_addr", mc_addr, 32'h0);
      check_eq("rst_mc_width", 32'(mc_width), 32'd0);
      next_cycle();
      req_valid = 1'b0;
      rst       = 1'b0;

      // Load extension vectors.
      do_load(OP_LB,  32'h104, 5'd5,  MC_W_BYTE, 32'h000000F0, 32'hFFFFFFF0, 1'b1);
      do_load(OP_LBU, 32'h104, 5'd6,  MC_W_BYTE, 32'h000000F0, 32'h000000F0, 1'b1);
      do_load(OP_LB,  32'h103, 5'd9,  MC_W_BYTE, 32'h0000007F, 32'h0000007F, 1'b1);
      do_load(OP_LH,  32'h102, 5'd10, MC_W_HALF, 32'h00008001, 32'hFFFF8001, 1'b1);
      do_load(OP_LHU, 32'h102, 5'd11, MC_W_HALF, 32'h00008001, 32'h00008001, 1'b1);
      do_load(OP_LW,  32'h100, 5'd0,  MC_W_WORD, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

      // Misaligned LH: pulse next cycle, no memory access, no writeback.
      drive_req(OP_LH, 32'h101, 32'h0, 5'd4);
      @(negedge clk);
      check_eq("mis_ld_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("mis_ld_pulse", 32'(misalign), 32'd1);
      check_eq("mis_ld_no_mc", 32'(mc_req), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("mis_ld_pulse_end", 32'(misalign), 32'd0);
      check_eq("mis_ld_no_mc2", 32'(mc_req), 32'd0);
      check_eq("mis_ld_no_wb", 32'(wb_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("mis_ld_no_wb2", 32'(wb_valid), 32'd0);
      next_cycle();

      // Misaligned SW: accepted, not buffered.
      drive_req(OP_SW, 32'h202, 32'h11111111, 5'd0);
      @(negedge clk);
      check_eq("mis_st_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("mis_st_pulse", 32'(misalign), 32'd1);
      next_cycle();
      @(negedge clk);
      check_eq("mis_st_no_mc", 32'(mc_req), 32'd0);
      next_cycle();

      // Store data is masked to the access width.
      drive_req(OP_SB, 32'h401, 32'h12345678, 5'd0);
      next_cycle();
      drive_req(OP_SH, 32'h402, 32'hCAFEBABE, 5'd0);
      next_cycle();
      req_valid = 1'b0;
      drain_store(32'h401, 32'h00000078, MC_W_BYTE);
      drain_store(32'h402, 32'h0000BABE, MC_W_HALF);

      // Four back-to-back SW fill the buffer; the fifth waits past the pop cycle.
      drive_req(OP_SW, 32'h300, 32'hA0000011, 5'd0);
      @(negedge clk); check_eq("full_ready0", 32'(req_ready), 32'd1);
      next_cycle();
      drive_req(OP_SW, 32'h304, 32'hA0000022, 5'd0);
      @(negedge clk); check_eq("full_ready1", 32'(req_ready), 32'd1);
      next_cycle();
      drive_req(OP_SW, 32'h308, 32'hA0000033, 5'd0);
      @(negedge clk);
      check_eq("full_ready2", 32'(req_ready), 32'd1);
      check_eq("full_issue0", 32'(mc_req), 32'd1);
      check_eq("full_issue0_addr", mc_addr, 32'h300);
      check_eq("full_issue0_data", mc_wdata, 32'hA0000011);
      next_cycle();
      drive_req(OP_SW, 32'h30C, 32'hA0000044, 5'd0);
      @(negedge clk);
      check_eq("full_ready3", 32'(req_ready), 32'd1);
      check_eq("full_issue_once", 32'(mc_req), 32'd0);
      next_cycle();
      drive_req(OP_SW, 32'h310, 32'hA0000055, 5'd0);
      @(negedge clk); check_eq("full_stall_a", 32'(req_ready), 32'd0);
      next_cycle();
      mc_done = 1'b1;
      @(negedge clk); check_eq("full_stall_pop", 32'(req_ready), 32'd0);
      next_cycle();
      mc_done = 1'b0;
      @(negedge clk); check_eq("full_ready_after", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      drain_store(32'h304, 32'hA0000022, MC_W_WORD);
      drain_store(32'h308, 32'hA0000033, MC_W_WORD);
      drain_store(32'h30C, 32'hA0000044, MC_W_WORD);
      drain_store(32'h310, 32'hA0000055, MC_W_WORD);

      // Load to a buffered word stalls until the store completes.
      drive_req(OP_SW, 32'h200, 32'h00000099, 5'd0);
      next_cycle();
      drive_req(OP_LH, 32'h202, 32'h0, 5'd7);
      @(negedge clk); check_eq("raw_stall_idle", 32'(req_ready), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("raw_stall_streq", 32'(req_ready), 32'd0);
      check_eq("raw_st_issue", 32'(mc_req), 32'd1);
      check_eq("raw_st_addr", mc_addr, 32'h200);
      next_cycle();
      mc_done = 1'b1;
      @(negedge clk); check_eq("raw_stall_done", 32'(req_ready), 32'd0);
      next_cycle();
      mc_done = 1'b0;
      @(negedge clk); check_eq("raw_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("raw_ld_issue", 32'(mc_req), 32'd1);
      check_eq("raw_ld_addr", mc_addr, 32'h202);
      check_eq("raw_ld_we", 32'(mc_we), 32'd0);
      next_cycle();
      mc_done  = 1'b1;
      mc_rdata = 32'h00001234;
      next_cycle();
      mc_done  = 1'b0;
      @(negedge clk);
      check_eq("raw_wb_valid", 32'(wb_valid), 32'd1);
      check_eq("raw_wb_data", wb_data, 32'h00001234);
      check_eq("raw_wb_rd", 32'(wb_rd), 32'd7);
      next_cycle();

      // Flush in LD_WAIT: completion consumed, writeback suppressed.
      drive_req(OP_LW, 32'h100, 32'h0, 5'd3);
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush    = 1'b0;
      mc_done  = 1'b1;
      mc_rdata = 32'h55;
      @(negedge clk); check_eq("flw_no_wb_a", 32'(wb_valid), 32'd0);
      next_cycle();
      mc_done = 1'b0;
      @(negedge clk);
      check_eq("flw_no_wb_b", 32'(wb_valid), 32'd0);
      check_eq("flw_no_wb_we", 32'(wb_we), 32'd0);
      next_cycle();
      do_load(OP_LW, 32'h108, 5'd12, MC_W_WORD, 32'h0BADF00D, 32'h0BADF00D, 1'b1);

      // Flush in LD_REQ: no request leaves.
      drive_req(OP_LW, 32'h10C, 32'h0, 5'd13);
      next_cycle();
      req_valid = 1'b0;
      flush     = 1'b1;
      @(negedge clk); check_eq("flr_no_mc", 32'(mc_req), 32'd0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      check_eq("flr_no_mc2", 32'(mc_req), 32'd0);
      check_eq("flr_idle_ready", 32'(req_ready), 32'd1);
      next_cycle();
      @(negedge clk); check_eq("flr_no_wb", 32'(wb_valid), 32'd0);
      next_cycle();

      // Reset during ST_WAIT with three buffered stores.
      drive_req(OP_SW, 32'h500, 32'h1, 5'd0);
      next_cycle();
      drive_req(OP_SW, 32'h504, 32'h2, 5'd0);
      next_cycle();
      drive_req(OP_SW, 32'h508, 32'h3, 5'd0);
      @(negedge clk); check_eq("rstw_issue", 32'(mc_req), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check_eq("rstw_mc_req", 32'(mc_req), 32'd0);
      check_eq("rstw_ready", 32'(req_ready), 32'd0);
      next_cycle();
      rst      = 1'b0;
      req_op   = OP_LW;
      req_addr = 32'h504;
      mc_done  = 1'b1;
      @(negedge clk);
      check_eq("rstw_empty_ready", 32'(req_ready), 32'd1);
      check_eq("rstw_idle_no_mc", 32'(mc_req), 32'd0);
      next_cycle();
      mc_done = 1'b0;
      @(negedge clk);
      check_eq("rstw_no_drain", 32'(mc_req), 32'd0);
      check_eq("rstw_late_done", 32'(wb_valid), 32'd0);
      next_cycle();
      @(negedge clk); check_eq("rstw_no_drain2", 32'(mc_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
